matrix_scan_scheduler: RTL
==========================

// Module: matrix_scan_scheduler
// PURPOSE
//  Column-scan scheduler for the 5x7 LED matrix (columns C0..C4, rows L0..L6).
//  Holds a double-buffered frame and drives one column at a time, stepping on a scan tick.
//  Inserts a blanking gap between columns to prevent ghosting.
//  New frames from the pattern/decoder logic are accepted by valid/ready; they swap in only at frame boundaries.
// PARAMETERS
//  COLS           5  number of matrix columns
//  ROWS           7  number of matrix rows
//  BLANK_CYCLES   4  clk50Mhz cycles, all outputs inactive, before each column is driven (>=1)
//  COL_ACTIVE_LOW 1  1: selected column driven 0, others 1; 0: inverted
//  ROW_ACTIVE_LOW 0  1: lit row driven 0; 0: lit row driven 1
// PORTS
//  clk50Mhz    in   1          system clock; the only clock
//  rst         in   1          synchronous reset, active-high
//  scan_tick   in   1          one-cycle enable from the divider; ends the current column
//  frame_data  in   COLS*ROWS  column-major: column c = [c*ROWS +: ROWS]; bit r set = row r lit
//  frame_valid in   1          frame_data is valid; source holds data until accepted
//  frame_ready out  1          back buffer is empty; transfer when valid & ready
//  col         out  COLS       column drive (bit c -> Cc), polarity per COL_ACTIVE_LOW
//  row         out  ROWS       row drive (bit r -> Lr), polarity per ROW_ACTIVE_LOW
//  frame_start out  1          one-cycle pulse on the cycle column 0 begins driving
//  col_idx     out  3          index of the column being or about to be driven
// BEHAVIOUR
//  - All outputs are registered. State changes take effect on the rising clk50Mhz edge.
//  - Reset (sync, rst=1 at edge):
//      state=BLANK, blank_cnt=0, col_idx=COLS-1.
//      front=0, back=0, pending=0, frame_ready=1, frame_start=0.
//      col = all inactive; row = all unlit.
//    rst has priority over every other input. Asserting it mid-scan discards any pending frame and the displayed frame.
//  - FSM states:
//    BLANK: col and row are inactive. blank_cnt increments each cycle. scan_tick is ignored.
//      When blank_cnt == BLANK_CYCLES-1: move to DRIVE, col_idx <= (col_idx==COLS-1) ? 0 : col_idx+1.
//    DRIVE: col is one-hot at col_idx; row = front column col_idx.
//      On scan_tick: move to BLANK with blank_cnt=0, and drive outputs inactive on the next cycle.
//      Without scan_tick, hold indefinitely.
//  - After reset, the first column driven is column 0, BLANK_CYCLES cycles after rst deasserts.
//  - Frame boundary = the BLANK->DRIVE transition into column 0.
//    On that edge frame_start=1 for one cycle.
//    If pending=1: front<=back and pending<=0, and the column-0 row output uses the new data on that same edge.
//  - Handshake:
//      frame_ready = ~pending.
//      On valid & ready: back<=frame_data, pending<=1, so ready drops on the next cycle.
//      ready returns 1 the cycle after the swap.
//      A transfer on the boundary edge while pending=0 is not swapped until the next boundary.
//      Transfer and swap cannot coincide, because a swap needs pending=1, i.e. ready=0.
//  - col_idx wraps COLS-1 -> 0. No other column order exists. Exactly one column is active in DRIVE; none is active in BLANK.
//  - A frame_valid held low while ready does nothing. The displayed frame repeats indefinitely.
// TESTING
//  1. rst 1 cycle, defaults:
//     -> col=5'b11111, row=7'b0000000, frame_ready=1 immediately.
//     -> 4 cycles later: col=5'b11110, row=0, frame_start=1 for exactly 1 cycle.
//  2. Send 5 scan_ticks, each while in DRIVE:
//     -> col steps 11110,11101,11011,10111,01111, then back to 11110.
//     -> Each column is preceded by exactly 4 cycles of col=11111, row=0.
//  3. Present frame_data with column 0 = 7'h55 and column 4 = 7'h2A while scanning column 2:
//     -> accepted at once; frame_ready=0.
//     -> columns 2..4 still show the old frame.
//     -> next column 0 shows row=7'h55 with frame_start=1; ready=1 on the following cycle.
//  4. Pulse scan_tick during BLANK -> ignored; the blank length stays 4 and col_idx advances by exactly 1.
//  5. Hold frame_valid with frame B while frame A is pending:
//     -> B is not taken until the cycle after A swaps.
//     -> A is displayed for a full frame, then B at the following boundary.
//  6. Assert rst while driving column 3 with a frame pending:
//     -> next cycle col=11111, row=0, frame_ready=1.
//     -> after restart, column 0 shows row=0 (the pending frame is discarded).

Source files
------------

// File: rtl/matrix_scan_scheduler.sv
// Column-scan scheduler for a 5x7 LED matrix.
// Double-buffered frame, blanking gap before each column, valid/ready frame intake.
module matrix_scan_scheduler #(
  parameter int COLS           = 5,
  parameter int ROWS           = 7,
  parameter int BLANK_CYCLES   = 4,
  parameter bit COL_ACTIVE_LOW = 1'b1,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk50Mhz,
  input  logic                 rst,
  input  logic                 scan_tick,
  input  logic [COLS*ROWS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [COLS-1:0]      col,
  output logic [ROWS-1:0]      row,
  output logic                 frame_start,
  output logic [2:0]           col_idx
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  localparam logic [2:0] IDX_LAST = 3'(COLS - 1);
  localparam logic [COLS-1:0] COL_OFF = COL_ACTIVE_LOW ? {COLS{1'b1}} : '0;
  localparam logic [ROWS-1:0] ROW_OFF = ROW_ACTIVE_LOW ? {ROWS{1'b1}} : '0;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        cnt, cnt_n;
  logic [2:0]           idx_n, idx_w;
  logic [COLS*ROWS-1:0] front, front_n;
  logic [COLS*ROWS-1:0] back, back_n;
  logic                 ready_n;
  logic [COLS-1:0]      col_n, col_hot;
  logic [ROWS-1:0]      row_n, row_bits;
  logic                 fs_n;
  logic                 blank_done, boundary, swap, xfer;

  // pending is held as ~frame_ready
  always_comb begin
    idx_w      = (col_idx == IDX_LAST) ? 3'd0 : col_idx + 3'd1;
    blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    boundary   = blank_done && (idx_w == 3'd0);
    swap       = boundary && !frame_ready;
    xfer       = frame_valid && frame_ready;
    front_n    = swap ? back : front;
    back_n     = xfer ? frame_data : back;
    ready_n    = swap ? 1'b1 : (xfer ? 1'b0 : frame_ready);
    col_hot    = COLS'(1) << idx_w;
    row_bits   = front_n[ROWS*int'(idx_w) +: ROWS];
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = col_idx;
    col_n   = col;
    row_n   = row;
    fs_n    = 1'b0;
    unique case (state)
      BLANK: begin
        col_n = COL_OFF;
        row_n = ROW_OFF;
        if (blank_done) begin
          state_n = DRIVE;
          cnt_n   = '0;
          idx_n   = idx_w;
          col_n   = COL_ACTIVE_LOW ? ~col_hot : col_hot;
          row_n   = ROW_ACTIVE_LOW ? ~row_bits : row_bits;
          fs_n    = boundary;
        end else begin
          cnt_n = cnt + BW'(1);
        end
      end
      DRIVE: begin
        if (scan_tick) begin
          state_n = BLANK;
          cnt_n   = '0;
          col_n   = COL_OFF;
          row_n   = ROW_OFF;
        end
      end
      default: state_n = BLANK;
    endcase
  end

  always_ff @(posedge clk50Mhz) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      col_idx     <= IDX_LAST;
      front       <= '0;
      back        <= '0;
      frame_ready <= 1'b1;
      frame_start <= 1'b0;
      col         <= COL_OFF;
      row         <= ROW_OFF;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      col_idx     <= idx_n;
      front       <= front_n;
      back        <= back_n;
      frame_ready <= ready_n;
      frame_start <= fs_n;
      col         <= col_n;
      row         <= row_n;
    end
  end

endmodule
